uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, 8, number of FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Parameter IRQ_THRESH, 4, fill level at which irq asserts; range 1..DEPTH.
REQ-003 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  9  received character from the upstream UART receiver; bit 8 is the receiver's extra/parity bit.
REQ-006 ld  input  1  one-cycle strobe; data_in SHALL be captured on the cycle ld=1.
REQ-007 address  input  2  Avalon-MM slave word address.
REQ-008 read  input  1  Avalon-MM read; asserted for exactly one cycle per transfer, no waitrequest.
REQ-009 chipselect  input  1  Avalon-MM slave select.
REQ-010 readdata  output  32  Avalon-MM read data, read latency 0.
REQ-011 irq  output  1  level-sensitive interrupt request.

Function
REQ-012 The block SHALL hold a DEPTH x 9-bit circular FIFO with write pointer, read pointer and a count of log2(DEPTH)+1 bits.
REQ-013 A push occurs when ld=1 and (count<DEPTH or a pop occurs in the same cycle); the entry is written at the write pointer, which then increments modulo DEPTH.
REQ-014 A pop occurs when chipselect=1, read=1, address=0 and count>0; the read pointer then increments modulo DEPTH.
REQ-015 Push and pop in the same cycle SHALL leave count unchanged, including at count=DEPTH (no overrun).
REQ-016 ld=1 with count=DEPTH and no pop SHALL discard data_in, set sticky overrun=1, and increment an 8-bit drop counter that saturates at 255.
REQ-017 Pop with count=0 SHALL be ignored; a simultaneous push SHALL still complete.
REQ-018 Address 0 read: readdata[8:0]=FIFO head, readdata[31]=1 if count>0, else readdata=0.
REQ-019 Address 1 read: readdata[0]=empty, [1]=full, [2]=overrun, [15:8]=count (zero-extended), all other bits 0.
REQ-020 An address-1 read SHALL clear overrun on the following edge; an overrun event in that same cycle SHALL leave overrun=1.
REQ-021 Address 2 read: readdata[7:0]=drop counter; that read SHALL clear the counter unless a drop occurs in the same cycle, in which case the counter becomes 1.
REQ-022 Address 3 read SHALL return 0 and change no state.
REQ-023 readdata SHALL be 0 whenever chipselect=0 or read=0.
REQ-024 Reads SHALL be combinational from current state; the resulting state change becomes visible on the next cycle.

Reset
REQ-025 reset_n=0 SHALL asynchronously clear pointers, count, overrun, drop counter and irq; FIFO storage need not be cleared.
REQ-026 After reset the status word SHALL read 0x00000001 (empty).
REQ-027 A reset asserted mid-transfer SHALL discard all buffered data; an ld arriving while reset_n=0 SHALL be ignored.

Configuration
REQ-028 Macro UART_RX_FIFO_IRQ_EN: when defined, irq SHALL be a registered output equal to (count>=IRQ_THRESH) or overrun, updated one cycle after the causing event.
REQ-029 When UART_RX_FIFO_IRQ_EN is undefined, the irq port SHALL exist and be tied to 0, and no interrupt logic SHALL be synthesised.

Verification
REQ-030 Reset, then read address 1 -> readdata=0x00000001; read address 0 -> readdata=0x00000000.
REQ-031 Push 0x041, 0x142, 0x043; three address-0 reads -> 0x80000041, 0x80000142, 0x80000043; status then 0x00000001.
REQ-032 DEPTH=8: push 10 bytes 0x00..0x09 -> status 0x00000806, address 2 reads 0x02, a second address-2 read returns 0x00, and eight pops return 0x00..0x07.
REQ-033 FIFO full, ld coincident with address-0 read -> pop returns the oldest byte, the new byte is stored, count stays 8, overrun unchanged.
REQ-034 With UART_RX_FIFO_IRQ_EN, IRQ_THRESH=4: the 4th push raises irq the next cycle; one pop lowers it the cycle after; without the macro, irq stays 0 throughout.
REQ-035 Assert reset_n=0 with count=5 and overrun=1 -> all outputs clear immediately, status reads 0x00000001 after release.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- receive-side character FIFO between a UART receiver and an
// Avalon-MM slave port.
//
// Characters are 9 bits wide (bit 8 is the receiver's extra/parity bit).
// Register map, word addressed:
//   0 : data    -- [31] valid, [8:0] FIFO head; reading pops one entry
//   1 : status  -- [0] empty, [1] full, [2] overrun, [15:8] count; reading clears overrun
//   2 : drops   -- [7:0] saturating count of discarded characters; reading clears it
//   3 : reserved, reads 0
//
// Build option: define UART_RX_FIFO_IRQ_EN to build the level interrupt.
// The interrupt is (count >= IRQ_THRESH) | overrun.
// When the macro is not defined, irq is tied low and no interrupt logic is built.

module uart_rx_fifo #(
    parameter int DEPTH      = 8,   // power of two, 2..256
    parameter int IRQ_THRESH = 4    // 1..DEPTH
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [8:0]  data_in,
    input  logic        ld,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        chipselect,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Storage and state
    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overrun;
    logic [7:0]    r_drop_cnt;

    // Decoded bus accesses and FIFO events
    logic          w_rd_en;
    logic          w_rd_data;
    logic          w_rd_stat;
    logic          w_rd_drop;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [AW:0]   w_count_next;
    logic          w_overrun_next;
    logic [7:0]    w_drop_next;
    logic [7:0]    w_count_byte;

    assign w_rd_en   = chipselect & read;
    assign w_rd_data = w_rd_en & (address == 2'd0);
    assign w_rd_stat = w_rd_en & (address == 2'd1);
    assign w_rd_drop = w_rd_en & (address == 2'd2);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // character when the head is being read at the same time.
    assign w_pop  = w_rd_data & ~w_empty;
    assign w_push = ld & (~w_full | w_pop);
    assign w_drop = ld & w_full & ~w_pop;

    // Count field of the status word is 8 bits wide.  With DEPTH=256, a full
    // FIFO wraps the field to 0; the full flag still reports it.
    generate
        if (AW + 1 > 8) begin : g_cnt_trunc
            assign w_count_byte = r_count[7:0];
        end else begin : g_cnt_ext
            assign w_count_byte = {{(7-AW){1'b0}}, r_count};
        end
    endgenerate

    // Next fill level: simultaneous push and pop cancel out
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + (AW+1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - (AW+1)'(1);
        end
    end

    // Next overrun flag: a new drop wins over a clearing status read
    always_comb begin
        w_overrun_next = r_overrun;
        if (w_rd_stat) begin
            w_overrun_next = 1'b0;
        end
        if (w_drop) begin
            w_overrun_next = 1'b1;
        end
    end

    // Next drop counter: read-to-clear, a drop in the clearing cycle leaves 1
    always_comb begin
        w_drop_next = r_drop_cnt;
        if (w_rd_drop) begin
            w_drop_next = w_drop ? 8'd1 : 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            w_drop_next = r_drop_cnt + 8'd1;
        end
    end

    // Character storage, no reset so it maps onto plain memory
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers, fill level and sticky status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overrun  <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_next;
            r_overrun  <= w_overrun_next;
            r_drop_cnt <= w_drop_next;
        end
    end

    // Zero-latency read mux; idle bus cycles return 0
    always_comb begin
        readdata = 32'd0;
        if (w_rd_en) begin
            case (address)
                2'd0: begin
                    if (!w_empty) begin
                        readdata[31]  = 1'b1;
                        readdata[8:0] = r_mem[r_rd_ptr];
                    end
                end
                2'd1: begin
                    readdata[0]    = w_empty;
                    readdata[1]    = w_full;
                    readdata[2]    = r_overrun;
                    readdata[15:8] = w_count_byte;
                end
                2'd2: begin
                    readdata[7:0] = r_drop_cnt;
                end
                default: begin
                    readdata = 32'd0;
                end
            endcase
        end
    end

`ifdef UART_RX_FIFO_IRQ_EN
    localparam logic [AW:0] THRESH_C = (AW+1)'(IRQ_THRESH);

    logic r_irq;

    // Interrupt registered from next-state values, so it follows the causing
    // event by exactly one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (w_count_next >= THRESH_C) | w_overrun_next;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=8, IRQ_THRESH=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later, or
// 1 ns after the rising edge for registered results.

module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_IRQ_EN
    localparam bit IRQ_EXP = 1'b1;
`else
    localparam bit IRQ_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  data_in = 9'd0;
    logic        ld = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0;
    logic        chipselect = 1'b0;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    uart_rx_fifo #(.DEPTH(8), .IRQ_THRESH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .ld         (ld),
        .address    (address),
        .read       (read),
        .chipselect (chipselect),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [8:0] d);
        @(negedge clk);
        data_in = d;
        ld = 1'b1;
        @(posedge clk);
        #1 ld = 1'b0;
        $display("push data=%03h", d);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        read = 1'b1;
        address = a;
        #1 d = readdata;
        @(posedge clk);
        #1 chipselect = 1'b0;
        read = 1'b0;
        $display("read addr=%0d data=%08h", a, d);
    endtask

    task automatic rd_push(input logic [1:0] a, input logic [8:0] din, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        read = 1'b1;
        address = a;
        data_in = din;
        ld = 1'b1;
        #1 d = readdata;
        @(posedge clk);
        #1 chipselect = 1'b0;
        read = 1'b0;
        ld = 1'b0;
        $display("read addr=%0d data=%08h with push data=%03h", a, d, din);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%0b exp=0", irq); end
        chipselect = 1'b1; address = 2'd1; read = 1'b0;
        #1;
        total++;
        if (readdata !== 32'd0) begin bad++; $display("FAIL idle_read got=%08h exp=00000000", readdata); end
        chipselect = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd1, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL rst_status got=%08h exp=00000001", d); end
        rd(2'd0, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL rst_data got=%08h exp=00000000", d); end
        rd(2'd2, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL rst_drops got=%08h exp=00000000", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        push(9'h041); push(9'h142); push(9'h043);
        rd(2'd1, d);
        total++;
        if (d !== 32'h0000_0300) begin bad++; $display("FAIL basic_status3 got=%08h exp=00000300", d); end
        rd(2'd0, d);
        total++;
        if (d !== 32'h8000_0041) begin bad++; $display("FAIL basic_pop0 got=%08h exp=80000041", d); end
        rd(2'd0, d);
        total++;
        if (d !== 32'h8000_0142) begin bad++; $display("FAIL basic_pop1 got=%08h exp=80000142", d); end
        rd(2'd0, d);
        total++;
        if (d !== 32'h8000_0043) begin bad++; $display("FAIL basic_pop2 got=%08h exp=80000043", d); end
        rd(2'd1, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL basic_empty got=%08h exp=00000001", d); end
        rd(2'd3, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL addr3 got=%08h exp=00000000", d); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic [31:0] exp;
        for (int i = 0; i < 10; i++) push(9'(i));
        rd(2'd1, d);
        total++;
        if (d !== 32'h0000_0806) begin bad++; $display("FAIL ovr_status got=%08h exp=00000806", d); end
        rd(2'd1, d);
        total++;
        if (d !== 32'h0000_0802) begin bad++; $display("FAIL ovr_cleared got=%08h exp=00000802", d); end
        rd(2'd2, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("FAIL ovr_drops got=%08h exp=00000002", d); end
        rd(2'd2, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL ovr_drops_clr got=%08h exp=00000000", d); end
        for (int i = 0; i < 8; i++) begin
            exp = 32'h8000_0000 | 32'(i);
            rd(2'd0, d);
            total++;
            if (d !== exp) begin bad++; $display("FAIL ovr_pop%0d got=%08h exp=%08h", i, d, exp); end
        end
        rd(2'd1, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL ovr_empty got=%08h exp=00000001", d); end
    endtask

    task automatic test_full_pop_push();
        logic [31:0] d;
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) push(9'(8'h10 + i));
        rd_push(2'd0, 9'h1AA, d);
        total++;
        if (d !== 32'h8000_0010) begin bad++; $display("FAIL full_pp_pop got=%08h exp=80000010", d); end
        rd(2'd1, d);
        total++;
        if (d !== 32'h0000_0802) begin bad++; $display("FAIL full_pp_status got=%08h exp=00000802", d); end
        rd(2'd2, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL full_pp_drops got=%08h exp=00000000", d); end
        for (int i = 1; i < 9; i++) begin
            exp = (i == 8) ? 32'h8000_01AA : (32'h8000_0010 + 32'(i));
            rd(2'd0, d);
            total++;
            if (d !== exp) begin bad++; $display("FAIL full_pp_pop%0d got=%08h exp=%08h", i, d, exp); end
        end
    endtask

    task automatic test_empty_pop_push();
        logic [31:0] d;
        rd_push(2'd0, 9'h055, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL empty_pp_read got=%08h exp=00000000", d); end
        rd(2'd1, d);
        total++;
        if (d !== 32'h0000_0100) begin bad++; $display("FAIL empty_pp_status got=%08h exp=00000100", d); end
        rd(2'd0, d);
        total++;
        if (d !== 32'h8000_0055) begin bad++; $display("FAIL empty_pp_pop got=%08h exp=80000055", d); end
    endtask

    task automatic test_sticky();
        logic [31:0] d;
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) push(9'(8'h20 + i));
        rd_push(2'd1, 9'h0FF, d);
        total++;
        if (d !== 32'h0000_0802) begin bad++; $display("FAIL sticky_pre got=%08h exp=00000802", d); end
        rd(2'd1, d);
        total++;
        if (d !== 32'h0000_0806) begin bad++; $display("FAIL sticky_kept got=%08h exp=00000806", d); end
        rd(2'd1, d);
        total++;
        if (d !== 32'h0000_0802) begin bad++; $display("FAIL sticky_clr got=%08h exp=00000802", d); end
        rd_push(2'd2, 9'h0FE, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL drop_rd_drop got=%08h exp=00000001", d); end
        rd(2'd2, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL drop_restart got=%08h exp=00000001", d); end
        rd(2'd2, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL drop_clr got=%08h exp=00000000", d); end
        @(negedge clk);
        data_in = 9'h111;
        ld = 1'b1;
        repeat (260) @(posedge clk);
        #1 ld = 1'b0;
        $display("push data=111 held 260 cycles while full");
        rd(2'd2, d);
        total++;
        if (d !== 32'hFF) begin bad++; $display("FAIL drop_sat got=%08h exp=000000ff", d); end
        rd(2'd1, d);
        total++;
        if (d !== 32'h0000_0806) begin bad++; $display("FAIL sat_status got=%08h exp=00000806", d); end
        for (int i = 0; i < 8; i++) begin
            exp = 32'h8000_0020 + 32'(i);
            rd(2'd0, d);
            total++;
            if (d !== exp) begin bad++; $display("FAIL sticky_pop%0d got=%08h exp=%08h", i, d, exp); end
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic [31:0] exp;
        push(9'h030); push(9'h031); push(9'h032);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_below got=%0b exp=0", irq); end
        push(9'h033);
        total++;
        if (irq !== IRQ_EXP) begin bad++; $display("FAIL irq_raise got=%0b exp=%0b", irq, IRQ_EXP); end
        rd(2'd0, d);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_lower got=%0b exp=0", irq); end
        total++;
        if (d !== 32'h8000_0030) begin bad++; $display("FAIL irq_pop got=%08h exp=80000030", d); end
        for (int i = 1; i < 4; i++) begin
            exp = 32'h8000_0030 + 32'(i);
            rd(2'd0, d);
            total++;
            if (d !== exp) begin bad++; $display("FAIL irq_drain%0d got=%08h exp=%08h", i, d, exp); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        for (int i = 0; i < 9; i++) push(9'(8'h60 + i));
        for (int i = 0; i < 3; i++) rd(2'd0, d);
        total++;
        if (irq !== IRQ_EXP) begin bad++; $display("FAIL mid_irq_pre got=%0b exp=%0b", irq, IRQ_EXP); end
        @(negedge clk);
        #2;
        ld = 1'b1;
        data_in = 9'h1FF;
        chipselect = 1'b1;
        read = 1'b1;
        address = 2'd1;
        reset_n = 1'b0;
        #1;
        total++;
        if (readdata !== 32'h1) begin bad++; $display("FAIL mid_status got=%08h exp=00000001", readdata); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%0b exp=0", irq); end
        address = 2'd0;
        #1;
        total++;
        if (readdata !== 32'h0) begin bad++; $display("FAIL mid_data got=%08h exp=00000000", readdata); end
        @(posedge clk);
        #1;
        total++;
        if (readdata !== 32'h0) begin bad++; $display("FAIL mid_hold got=%08h exp=00000000", readdata); end
        @(negedge clk);
        ld = 1'b0;
        chipselect = 1'b0;
        read = 1'b0;
        reset_n = 1'b1;
        $display("reset pulse with ld asserted");
        rd(2'd1, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL mid_post_status got=%08h exp=00000001", d); end
        rd(2'd2, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL mid_post_drops got=%08h exp=00000000", d); end
        rd(2'd0, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL mid_post_data got=%08h exp=00000000", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_full_pop_push();
        test_empty_pop_push();
        test_sticky();
        test_irq();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
